// File: rtl/net_pkg.sv
// Shared IPv4 receive-path types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the receive FSM state enum and the IPv4 header constants used by the
// network and transport stages.
package net_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [3:0] IPV4_VER = 4'd4;
  localparam logic [3:0] IHL_MIN  = 4'd5;
  localparam logic [7:0] PROT_TCP = 8'd6;
  localparam logic [7:0] PROT_UDP = 8'd17;

endpackage

// File: rtl/ones_comp_fold.sv
// One's-complement fold of a 32-bit plain sum down to 16 bits.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   sum  - 32-bit plain binary sum of 16-bit halves
//   fold - 16-bit one's-complement result (two end-around folds)
module ones_comp_fold (
  input  logic [31:0] sum,
  output logic [15:0] fold
);

  logic [16:0] s1;

  // The first fold can carry out at most once; the second fold absorbs that
  // carry and cannot overflow again.
  always_comb begin
    s1   = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    fold = s1[15:0] + {15'd0, s1[16]};
  end

endmodule

// File: rtl/ipv4_rx_layer.sv
// IPv4 receive stage: parse/validate the header, strip it and padding, forward the payload.
// Latency: 1 cycle from an accepted payload word to upper_op/upper_data.
// Backpressure: none; downstream must take one word per cycle.
//
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   rcv_op_st/rcv_op/rcv_op_end     - link-layer word strobes, rcv_data the word
//   local_ip                        - this node's address (quasi-static)
//   upper_op_st/upper_op/upper_op_end, upper_data - payload word stream
//   upper_data_len, prot_type, pseudo_crc_sum,
//   source_addr_o, dest_addr_o      - per-datagram metadata for transport_layer
//   drop_o, len_err_o               - one-cycle event pulses
module ipv4_rx_layer
  import net_pkg::*;
#(
  parameter bit ADDR_FILTER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rcv_op_st,
  input  logic        rcv_op,
  input  logic        rcv_op_end,
  input  logic [31:0] rcv_data,
  input  logic [31:0] local_ip,
  output logic        upper_op_st,
  output logic        upper_op,
  output logic        upper_op_end,
  output logic [31:0] upper_data,
  output logic [15:0] upper_data_len,
  output logic [7:0]  prot_type,
  output logic [15:0] pseudo_crc_sum,
  output logic [31:0] source_addr_o,
  output logic [31:0] dest_addr_o,
  output logic        drop_o,
  output logic        len_err_o
);

  state_t      state;
  logic [3:0]  hw;
  logic [3:0]  ver_q;
  logic [3:0]  ihl_q;
  logic [15:0] tlen_q;
  logic        mf_q;
  logic [12:0] off_q;
  logic [7:0]  proto_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] hdr_acc;
  logic [14:0] rem;
  logic        first_q;

  logic [3:0]  last_hw;
  logic        hdr_last;
  logic [15:0] ihl_bytes;
  logic [15:0] pay_len;
  logic [31:0] dst_eff;
  logic [31:0] hdr_sum;
  logic [31:0] ps_sum;
  logic [16:0] rem_round;
  logic [15:0] hdr_fold;
  logic [15:0] ps_fold;
  logic        hdr_bad;

  always_comb begin
    // A malformed IHL below the minimum still runs through the fixed
    // 5-word header so the decision point is always after the addresses.
    last_hw   = (ihl_q < IHL_MIN) ? 4'd4 : (ihl_q - 4'd1);
    hdr_last  = (hw == last_hw);
    ihl_bytes = {10'd0, ihl_q, 2'b00};
    pay_len   = tlen_q - ihl_bytes;
    // With no options the destination word is the deciding word itself and
    // has not been registered yet.
    dst_eff   = (hw == 4'd4) ? rcv_data : dst_q;
    hdr_sum   = hdr_acc + {16'd0, rcv_data[31:16]} + {16'd0, rcv_data[15:0]};
    ps_sum    = {16'd0, src_q[31:16]} + {16'd0, src_q[15:0]}
              + {16'd0, dst_eff[31:16]} + {16'd0, dst_eff[15:0]}
              + {24'd0, proto_q} + {16'd0, pay_len};
    rem_round = {1'b0, pay_len} + 17'd3;
    // tlen <= 4*IHL covers both a short total length and an empty payload.
    hdr_bad   = (ver_q != IPV4_VER) || (ihl_q < IHL_MIN) || (tlen_q <= ihl_bytes)
             || (hdr_fold != 16'hFFFF) || mf_q || (off_q != 13'd0)
             || (ADDR_FILTER_EN && (dst_eff != local_ip));
  end

  ones_comp_fold u_hdr_fold (
    .sum  (hdr_sum),
    .fold (hdr_fold)
  );

  ones_comp_fold u_ps_fold (
    .sum  (ps_sum),
    .fold (ps_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      hw             <= 4'd0;
      ver_q          <= 4'd0;
      ihl_q          <= 4'd0;
      tlen_q         <= 16'd0;
      mf_q           <= 1'b0;
      off_q          <= 13'd0;
      proto_q        <= 8'd0;
      src_q          <= 32'd0;
      dst_q          <= 32'd0;
      hdr_acc        <= 32'd0;
      rem            <= 15'd0;
      first_q        <= 1'b0;
      upper_op_st    <= 1'b0;
      upper_op       <= 1'b0;
      upper_op_end   <= 1'b0;
      upper_data     <= 32'd0;
      upper_data_len <= 16'd0;
      prot_type      <= 8'd0;
      pseudo_crc_sum <= 16'd0;
      source_addr_o  <= 32'd0;
      dest_addr_o    <= 32'd0;
      drop_o         <= 1'b0;
      len_err_o      <= 1'b0;
    end else begin
      upper_op_st  <= 1'b0;
      upper_op     <= 1'b0;
      upper_op_end <= 1'b0;
      upper_data   <= 32'd0;
      drop_o       <= 1'b0;
      len_err_o    <= 1'b0;

      if (rcv_op && rcv_op_st) begin
        // A start word always restarts parsing; an interrupted payload is
        // reported but its last forwarded word never gets an end strobe.
        ver_q   <= rcv_data[31:28];
        ihl_q   <= rcv_data[27:24];
        tlen_q  <= rcv_data[15:0];
        hdr_acc <= {16'd0, rcv_data[31:16]} + {16'd0, rcv_data[15:0]};
        mf_q    <= 1'b0;
        off_q   <= 13'd0;
        proto_q <= 8'd0;
        src_q   <= 32'd0;
        dst_q   <= 32'd0;
        rem     <= 15'd0;
        first_q <= 1'b0;
        hw      <= 4'd1;
        if ((state == PAYLOAD) || rcv_op_end) len_err_o <= 1'b1;
        state   <= rcv_op_end ? IDLE : HEADER;
      end else if (rcv_op) begin
        case (state)
          HEADER: begin
            hdr_acc <= hdr_sum;
            hw      <= hw + 4'd1;
            case (hw)
              4'd1: begin
                mf_q  <= rcv_data[13];
                off_q <= rcv_data[12:0];
              end
              4'd2: proto_q <= rcv_data[23:16];
              4'd3: src_q   <= rcv_data;
              4'd4: dst_q   <= rcv_data;
              default: ;
            endcase
            if (hdr_last) begin
              upper_data_len <= pay_len;
              prot_type      <= proto_q;
              pseudo_crc_sum <= ps_fold;
              source_addr_o  <= src_q;
              dest_addr_o    <= dst_eff;
              rem            <= rem_round[16:2];
              first_q        <= 1'b1;
              if (hdr_bad) begin
                drop_o <= 1'b1;
                state  <= DROP;
              end else if (rcv_op_end) begin
                len_err_o <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= PAYLOAD;
              end
            end else if (rcv_op_end) begin
              len_err_o <= 1'b1;
              state     <= IDLE;
            end
          end
          PAYLOAD: begin
            upper_op    <= 1'b1;
            upper_data  <= rcv_data;
            upper_op_st <= first_q;
            first_q     <= 1'b0;
            rem         <= rem - 15'd1;
            if ((rem == 15'd1) || rcv_op_end) begin
              upper_op_end <= 1'b1;
              state        <= IDLE;
              if (rem != 15'd1) len_err_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx_layer.sv
module tb_ipv4_rx_layer;
  import net_pkg::*;

  localparam logic [31:0] LOCAL = 32'hC0A8_0105;
  localparam logic [31:0] SRC   = 32'h0A00_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rcv_op_st = 1'b0;
  logic        rcv_op = 1'b0;
  logic        rcv_op_end = 1'b0;
  logic [31:0] rcv_data = 32'd0;
  logic [31:0] local_ip = LOCAL;
  logic        upper_op_st;
  logic        upper_op;
  logic        upper_op_end;
  logic [31:0] upper_data;
  logic [15:0] upper_data_len;
  logic [7:0]  prot_type;
  logic [15:0] pseudo_crc_sum;
  logic [31:0] source_addr_o;
  logic [31:0] dest_addr_o;
  logic        drop_o;
  logic        len_err_o;

  always #5 clk = ~clk;

  ipv4_rx_layer #(.ADDR_FILTER_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rcv_op_st      (rcv_op_st),
    .rcv_op         (rcv_op),
    .rcv_op_end     (rcv_op_end),
    .rcv_data       (rcv_data),
    .local_ip       (local_ip),
    .upper_op_st    (upper_op_st),
    .upper_op       (upper_op),
    .upper_op_end   (upper_op_end),
    .upper_data     (upper_data),
    .upper_data_len (upper_data_len),
    .prot_type      (prot_type),
    .pseudo_crc_sum (pseudo_crc_sum),
    .source_addr_o  (source_addr_o),
    .dest_addr_o    (dest_addr_o),
    .drop_o         (drop_o),
    .len_err_o      (len_err_o)
  );

  int checks = 0;
  int errors = 0;
  int op_cnt = 0;
  int drop_cnt = 0;
  int lerr_cnt = 0;
  logic [33:0] exp_q[$];   // {st, end, data}
  logic [31:0] pkt[$];

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] pseudo_ref(input logic [31:0] s, input logic [31:0] d,
                                             input logic [7:0] p, input logic [15:0] len);
    logic [15:0] a;
    a = 16'h0;
    a = oc_add(a, s[31:16]);
    a = oc_add(a, s[15:0]);
    a = oc_add(a, d[31:16]);
    a = oc_add(a, d[15:0]);
    a = oc_add(a, {8'h00, p});
    a = oc_add(a, len);
    return a;
  endfunction

  // Monitor: scoreboard pop on each payload word, per-cycle strobe sanity, event counters.
  always @(negedge clk) begin : monitor
    logic [33:0] e;
    if (rst_n) begin
      checks++;
      if (!upper_op && (upper_op_st || upper_op_end || (upper_data != 32'd0))) begin
        errors++;
        $display("FAIL idle_strobes: st=%b end=%b data=%h, need all 0 while upper_op=0",
                 upper_op_st, upper_op_end, upper_data);
      end
      if (upper_op) begin
        op_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: st=%b end=%b data=%h, no word expected",
                   upper_op_st, upper_op_end, upper_data);
        end else begin
          e = exp_q.pop_front();
          if ({upper_op_st, upper_op_end, upper_data} !== e) begin
            errors++;
            $display("FAIL payload_word: got st=%b end=%b data=%h, want st=%b end=%b data=%h",
                     upper_op_st, upper_op_end, upper_data, e[33], e[32], e[31:0]);
          end
        end
      end
      if (drop_o) drop_cnt++;
      if (len_err_o) lerr_cnt++;
    end
  end

  task automatic build_pkt(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tlen,
                           input bit mf, input logic [31:0] dst, input logic [7:0] proto,
                           input bit bad_csum, input int n, input logic [7:0] tag);
    logic [15:0] s;
    logic [31:0] w;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0)              w = {ver, ihl, 8'h00, tlen};
      else if (i == 1)         w = {16'h1C46, mf ? 16'h2000 : 16'h0000};
      else if (i == 2)         w = {8'h40, proto, 16'h0000};
      else if (i == 3)         w = SRC;
      else if (i == 4)         w = dst;
      else if (i < int'(ihl))  w = 32'h0102_0300 + i;
      else                     w = {tag, 8'(i), 16'hA5C3 ^ 16'(i)};
      pkt.push_back(w);
    end
    s = 16'h0;
    for (int i = 0; i < int'(ihl); i++) begin
      w = pkt[i];
      s = oc_add(s, w[31:16]);
      s = oc_add(s, w[15:0]);
    end
    w = pkt[2];
    w[15:0] = bad_csum ? (~s ^ 16'h0100) : ~s;
    pkt[2] = w;
  endtask

  task automatic push_exp(input int first, input int k, input bit last_end);
    for (int j = 0; j < k; j++)
      exp_q.push_back({(j == 0), (last_end && (j == k - 1)), pkt[first + j]});
  endtask

  task automatic send(input int from, input int to, input int end_idx);
    for (int i = from; i <= to; i++) begin
      @(posedge clk); #1;
      rcv_op     = 1'b1;
      rcv_op_st  = (i == 0);
      rcv_op_end = (i == end_idx);
      rcv_data   = pkt[i];
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      rcv_op     = 1'b0;
      rcv_op_st  = 1'b0;
      rcv_op_end = 1'b0;
      rcv_data   = 32'hDEAD_BEEF;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({upper_op_st, upper_op, upper_op_end, upper_data, upper_data_len, prot_type,
         pseudo_crc_sum, source_addr_o, dest_addr_o, drop_o, len_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: op=%b data=%h len=%h prot=%h ps=%h src=%h dst=%h drop=%b lerr=%b, need all 0",
               upper_op, upper_data, upper_data_len, prot_type, pseudo_crc_sum,
               source_addr_o, dest_addr_o, drop_o, len_err_o);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_tcp;
    int d0, l0;
    build_pkt(IPV4_VER, 4'd5, 16'd60, 1'b0, LOCAL, PROT_TCP, 1'b0, 17, 8'h11);
    push_exp(5, 10, 1'b1);
    d0 = drop_cnt; l0 = lerr_cnt;
    send(0, 16, 16);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tcp_words_left: %0d words missing, want 0", exp_q.size()); end
    checks++;
    if (upper_data_len !== 16'd40) begin errors++; $display("FAIL tcp_len: got %0d want 40", upper_data_len); end
    checks++;
    if (prot_type !== PROT_TCP) begin errors++; $display("FAIL tcp_prot: got %0d want 6", prot_type); end
    checks++;
    if (pseudo_crc_sum !== pseudo_ref(SRC, LOCAL, PROT_TCP, 16'd40)) begin
      errors++;
      $display("FAIL tcp_pseudo: got %h want %h", pseudo_crc_sum, pseudo_ref(SRC, LOCAL, PROT_TCP, 16'd40));
    end
    checks++;
    if ({source_addr_o, dest_addr_o} !== {SRC, LOCAL}) begin
      errors++;
      $display("FAIL tcp_addrs: got %h/%h want %h/%h", source_addr_o, dest_addr_o, SRC, LOCAL);
    end
    checks++;
    if ((drop_cnt != d0) || (lerr_cnt != l0)) begin
      errors++;
      $display("FAIL tcp_events: drops %0d len_errs %0d, want 0 0", drop_cnt - d0, lerr_cnt - l0);
    end
  endtask

  task automatic test_options;
    int o0, l0;
    build_pkt(IPV4_VER, 4'd7, 16'd32, 1'b0, LOCAL, PROT_UDP, 1'b0, 9, 8'h22);
    push_exp(7, 1, 1'b1);
    o0 = op_cnt; l0 = lerr_cnt;
    send(0, 8, 8);
    idle(3);
    checks++;
    if ((exp_q.size() != 0) || (op_cnt - o0 != 1)) begin
      errors++;
      $display("FAIL opt_words: %0d out, %0d missing, want 1 out 0 missing", op_cnt - o0, exp_q.size());
    end
    checks++;
    if (upper_data_len !== 16'd4) begin errors++; $display("FAIL opt_len: got %0d want 4", upper_data_len); end
    checks++;
    if (lerr_cnt != l0) begin errors++; $display("FAIL opt_len_err: got %0d pulses want 0", lerr_cnt - l0); end
  endtask

  task automatic test_drops;
    int d0, o0;
    for (int k = 0; k < 3; k++) begin
      build_pkt(IPV4_VER, 4'd5, 16'd60, (k == 1), (k == 2) ? (LOCAL ^ 32'h1) : LOCAL,
                PROT_UDP, (k == 0), 17, 8'h33);
      d0 = drop_cnt; o0 = op_cnt;
      send(0, 16, 16);
      idle(3);
      checks++;
      if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop_pulse[%0d]: got %0d pulses want 1", k, drop_cnt - d0); end
      checks++;
      if (op_cnt != o0) begin errors++; $display("FAIL drop_quiet[%0d]: got %0d words want 0", k, op_cnt - o0); end
    end
  endtask

  task automatic test_trunc;
    int d0, l0;
    build_pkt(IPV4_VER, 4'd5, 16'd100, 1'b0, LOCAL, PROT_TCP, 1'b0, 11, 8'h44);
    push_exp(5, 6, 1'b1);
    d0 = drop_cnt; l0 = lerr_cnt;
    send(0, 10, 10);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL trunc_words_left: %0d missing want 0", exp_q.size()); end
    checks++;
    if ((lerr_cnt - l0 != 1) || (drop_cnt != d0)) begin
      errors++;
      $display("FAIL trunc_events: len_err %0d drop %0d, want 1 0", lerr_cnt - l0, drop_cnt - d0);
    end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL trunc_state: got %0d want %0d", dut.state, IDLE); end
    checks++;
    if (upper_data_len !== 16'd80) begin errors++; $display("FAIL trunc_len: got %0d want 80", upper_data_len); end
  endtask

  task automatic test_back_to_back;
    int l0;
    build_pkt(IPV4_VER, 4'd5, 16'd60, 1'b0, LOCAL, PROT_TCP, 1'b0, 15, 8'h55);
    push_exp(5, 3, 1'b0);
    l0 = lerr_cnt;
    send(0, 7, -1);
    build_pkt(IPV4_VER, 4'd5, 16'd28, 1'b0, LOCAL, PROT_TCP, 1'b0, 7, 8'h66);
    push_exp(5, 2, 1'b1);
    send(0, 6, 6);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_words_left: %0d missing want 0", exp_q.size()); end
    checks++;
    if (lerr_cnt - l0 != 1) begin errors++; $display("FAIL abort_len_err: got %0d pulses want 1", lerr_cnt - l0); end
    checks++;
    if (upper_data_len !== 16'd8) begin errors++; $display("FAIL abort_new_len: got %0d want 8", upper_data_len); end
  endtask

  task automatic test_stall_reset;
    int c0;
    build_pkt(IPV4_VER, 4'd5, 16'd60, 1'b0, LOCAL, PROT_TCP, 1'b0, 15, 8'h77);
    push_exp(5, 6, 1'b0);
    send(0, 8, -1);
    idle(1);
    #6;
    c0 = op_cnt;
    idle(3);
    #6;
    checks++;
    if (op_cnt != c0) begin errors++; $display("FAIL stall_words: got %0d words during stall want 0", op_cnt - c0); end
    send(9, 10, -1);
    idle(1);
    #6;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({upper_op_st, upper_op, upper_op_end, upper_data, upper_data_len, prot_type,
         pseudo_crc_sum, source_addr_o, dest_addr_o, drop_o, len_err_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: op=%b data=%h len=%h prot=%h ps=%h src=%h dst=%h, need all 0",
               upper_op, upper_data, upper_data_len, prot_type, pseudo_crc_sum, source_addr_o, dest_addr_o);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL prereset_words: %0d missing want 0", exp_q.size()); end
    #3;
    rst_n = 1'b1;
    idle(2);
    build_pkt(IPV4_VER, 4'd5, 16'd48, 1'b0, LOCAL, PROT_TCP, 1'b0, 13, 8'h88);
    push_exp(5, 7, 1'b1);
    send(0, 12, 12);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL postreset_words: %0d missing want 0", exp_q.size()); end
    checks++;
    if ({upper_data_len, pseudo_crc_sum} !== {16'd28, pseudo_ref(SRC, LOCAL, PROT_TCP, 16'd28)}) begin
      errors++;
      $display("FAIL postreset_meta: len %0d ps %h, want 28 %h", upper_data_len, pseudo_crc_sum,
               pseudo_ref(SRC, LOCAL, PROT_TCP, 16'd28));
    end
  endtask

  initial begin
    test_reset();
    test_tcp();
    test_options();
    test_drops();
    test_trunc();
    test_back_to_back();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv4_rx_layer.md
# ipv4_rx_layer

Receive-side IPv4 network stage between the Ethernet link-layer deframer and `transport_layer`. It takes the IP datagram as 32-bit words with start/valid/end strobes, then parses and validates the IPv4 header. It strips the header and any Ethernet padding, and forwards only the transport payload. Alongside the payload it presents the protocol, payload length and pseudo-header checksum that `transport_layer` needs.

## Interface
Parameters:
- `ADDR_FILTER_EN`, default 1: drop datagrams whose destination address differs from `local_ip`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rcv_op_st`  in  1  coincides with the first word of a datagram (IP word 0).
- `rcv_op`  in  1  word valid; may deassert mid-datagram (stall).
- `rcv_op_end`  in  1  coincides with the last word from the link layer, which may include padding.
- `rcv_data`  in  32  datagram word, big-endian.
- `local_ip`  in  32  this node's address; quasi-static.
- `upper_op_st`  out  1  marks the first payload word.
- `upper_op`  out  1  payload word valid.
- `upper_op_end`  out  1  marks the last payload word.
- `upper_data`  out  32  payload word.
- `upper_data_len`  out  16  payload bytes, computed as total_length − 4·IHL.
- `prot_type`  out  8  IP protocol field.
- `pseudo_crc_sum`  out  16  folded pseudo-header sum.
- `source_addr_o`, `dest_addr_o`  out  32  header addresses.
- `drop_o`  out  1  one-cycle pulse when a datagram is discarded.
- `len_err_o`  out  1  one-cycle pulse when a datagram is truncated or aborted.

## Operation
- FSM states are IDLE, HEADER, PAYLOAD and DROP.
- `rcv_op_st & rcv_op` moves the FSM to HEADER from any state and clears all counters and accumulators.
- The header word counter `hw` advances on each `rcv_op`. Fields are captured as follows:
  - hw0: version, IHL, total_length.
  - hw1: flags and fragment offset.
  - hw2: TTL, protocol, checksum.
  - hw3: source address.
  - hw4: destination address.
  - hw5..IHL−1: options, which are consumed and discarded.
- Header checksum: every header 16-bit half is added into a 32-bit accumulator, then end-around-folded twice. The header is valid if the result is 16'hFFFF.
- Drop conditions are any of the following:
  - version≠4
  - IHL<5
  - total_length<4·IHL
  - bad checksum
  - MF=1 or offset≠0
  - destination mismatch when `ADDR_FILTER_EN` is set
  - total_length=4·IHL, i.e. empty payload
- The drop decision is made on the last header word. A dropped datagram goes to DROP, pulses `drop_o` once, and emits no upper strobes until the next `rcv_op_st`.
- Otherwise the FSM enters PAYLOAD, with remaining words = ceil(upper_data_len/4).
- Each `rcv_op` in PAYLOAD forwards one word. When the remaining count reaches 1, that word carries `upper_op_end` and the FSM returns to IDLE. Later padding words are ignored.
- `pseudo_crc_sum` = fold(src_hi + src_lo + dst_hi + dst_lo + {8'h0,proto} + upper_data_len). Accumulate in 32 bits, then fold twice to 16 bits.
- Truncation: if `rcv_op_end` arrives in PAYLOAD before the count expires, that word is forwarded with `upper_op_end`, `len_err_o` pulses, and the FSM goes to IDLE. If `rcv_op_end` arrives in HEADER, nothing is forwarded and `len_err_o` pulses.
- Abort: `rcv_op_st` while in PAYLOAD pulses `len_err_o` and does not emit `upper_op_end` for the old datagram. The new datagram is processed normally.

## Timing
- Reset value of every output is 0.
- Payload latency is one cycle from a `rcv_op` word to `upper_op` and `upper_data`.
- `upper_op`, `upper_op_st` and `upper_op_end` are per-word strobes, and `upper_op_st`/`upper_op_end` only assert together with `upper_op`. For a one-word payload all three assert in the same cycle.
- `upper_data` is 0 whenever `upper_op` is 0.
- `prot_type`, `upper_data_len`, `pseudo_crc_sum` and the address outputs are registered and stable from the `upper_op_st` cycle. They are held until the next datagram's header rewrites them.
- `drop_o` asserts one cycle after the last header word.
- There is no backpressure; downstream must accept one word per cycle.

## Structure
- A shared package `net_pkg` holds:
  - the FSM state enum
  - constants IPV4_VER=4, PROT_TCP=8'd6, PROT_UDP=8'd17, IHL_MIN=5
- Sub-module `ones_comp_fold`: 32-bit sum in, 16-bit double end-around fold out. It is instantiated for both the header checksum and the pseudo-header sum, and is reusable by `transport_layer`.

## Test plan
- **Valid TCP datagram.** IHL=5, total_length=60, valid checksum, dst=`local_ip`, 15 words plus 2 padding words. Expect:
  - 10 payload words out with `upper_op_st` on the first and `upper_op_end` on the tenth, and no output for the padding words.
  - `upper_data_len`=40, `prot_type`=6.
  - `pseudo_crc_sum` matching the software reference.
- **Options.** IHL=7, total_length=32. Expect header words 5–6 skipped and 1 payload word with st, op and end asserted in the same cycle.
- **Drops.** Apply bad checksum, MF=1, and wrong destination as three separate datagrams. Expect `drop_o` once per datagram and zero `upper_op` cycles.
- **Truncation.** total_length=100 but `rcv_op_end` on IP word 10. Expect:
  - `upper_op_end` on payload word 5.
  - `len_err_o` pulsed.
  - FSM back in IDLE.
- **Stall and reset.** Deassert `rcv_op` for 3 cycles mid-payload, then assert `rst_n`=0 mid-payload. Expect:
  - No extra words during the stall.
  - All outputs 0 immediately on reset.
  - The next datagram parsed correctly.
